// File: rtl/bc0_bist_pkg.sv
// Shared widths, tap masks and state encoding for the bc0 BIST controller.
package bc0_bist_pkg;

   localparam int X_W   = 26;
   localparam int Z_W   = 11;
   localparam int CNT_W = 16;

   // Feedback masks: LFSR taps x25^x5^x1^x0, MISR taps m10^m8.
   localparam logic [X_W-1:0] LFSR_TAPS = 26'h2000023;
   localparam logic [Z_W-1:0] MISR_TAPS = 11'h500;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_COMPARE = 2'd2,
      ST_DONE    = 2'd3
   } bist_state_e;

   function automatic logic [Z_W-1:0] misr_step(input logic [Z_W-1:0] sig,
                                                input logic [Z_W-1:0] resp);
      return {sig[Z_W-2:0], ^(sig & MISR_TAPS)} ^ resp;
   endfunction

endpackage

// File: rtl/bc0_bist_lfsr.sv
// One combinational step of the 26-bit stimulus LFSR (shift left, feedback into bit 0).
module bc0_bist_lfsr
   import bc0_bist_pkg::*;
(
   input  logic [X_W-1:0] x_cur,
   output logic [X_W-1:0] x_nxt
);

   assign x_nxt = {x_cur[X_W-2:0], ^(x_cur & LFSR_TAPS)};

endmodule

// File: rtl/bc0_bist_ctrl.sv
// BIST sequencer for the combinational bc0 block: LFSR stimulus, MISR compaction,
// single-cycle golden-signature compare.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for start; outputs hold last signature/count
// ST_RUN     | one vector per cycle, response folded into MISR same cycle
// ST_COMPARE | one cycle: latch pass = (MISR == GOLDEN_SIG)
// ST_DONE    | results held until start, abort or reset
module bc0_bist_ctrl
   import bc0_bist_pkg::*;
#(
   parameter int unsigned      NUM_PATTERNS = 1024,
   parameter logic [X_W-1:0]   SEED         = 26'h0000001,
   parameter logic [Z_W-1:0]   GOLDEN_SIG   = 11'h000
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   output logic [X_W-1:0]     x_out,
   input  logic [Z_W-1:0]     z_in,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [Z_W-1:0]     signature,
   output logic [CNT_W-1:0]   pattern_count
);

   // An all-zero seed would lock the LFSR.
   localparam logic [X_W-1:0]   SEED_EFF = (SEED == '0) ? X_W'(1) : SEED;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS - 1);

   bist_state_e       state_q, state_d;
   logic [X_W-1:0]    x_q, x_d, x_step;
   logic [Z_W-1:0]    misr_q, misr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  remain_q, remain_d;
   logic              pass_q, pass_d;
   logic              load;

   bc0_bist_lfsr u_lfsr (
      .x_cur (x_q),
      .x_nxt (x_step)
   );

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      misr_d   = misr_q;
      cnt_d    = cnt_q;
      remain_d = remain_q;
      pass_d   = pass_q;
      load     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            load = start;
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
               pass_d  = 1'b0;
            end else begin
               misr_d   = misr_step(misr_q, z_in);
               x_d      = x_step;
               cnt_d    = cnt_q + CNT_W'(1);
               remain_d = remain_q - CNT_W'(1);
               if (remain_q == '0) state_d = ST_COMPARE;
            end
         end
         ST_COMPARE: begin
            if (abort) begin
               state_d = ST_IDLE;
               pass_d  = 1'b0;
            end else begin
               pass_d  = (misr_q == GOLDEN_SIG);
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (abort) begin
               state_d = ST_IDLE;
               pass_d  = 1'b0;
            end else begin
               load = start;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (load) begin
         state_d  = ST_RUN;
         x_d      = SEED_EFF;
         misr_d   = '0;
         cnt_d    = '0;
         remain_d = LAST_CNT;
         pass_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         x_q      <= '0;
         misr_q   <= '0;
         cnt_q    <= '0;
         remain_q <= '0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         misr_q   <= misr_d;
         cnt_q    <= cnt_d;
         remain_q <= remain_d;
         pass_q   <= pass_d;
      end
   end

   assign x_out         = x_q;
   assign signature     = misr_q;
   assign pattern_count = cnt_q;
   assign pass          = pass_q;
   assign busy          = (state_q == ST_RUN) || (state_q == ST_COMPARE);
   assign done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_bc0_bist_ctrl.sv
// Directed bench for bc0_bist_ctrl with NUM_PATTERNS=4, SEED=1, GOLDEN_SIG=0.
module tb_bc0_bist_ctrl;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          abort;
   logic [25:0]   x_out;
   logic [10:0]   z_in;
   logic          busy;
   logic          done;
   logic          pass;
   logic [10:0]   signature;
   logic [15:0]   pattern_count;

   int n_checks = 0;
   int n_errors = 0;
   int z_mode   = 0;   // 0: zero, 1: constant 1, 2: stand-in bc0 (x low bits ^ x high bits)

   always #5 clk = ~clk;

   always_comb begin
      z_in = '0;
      case (z_mode)
         1:       z_in = 11'h001;
         2:       z_in = x_out[10:0] ^ x_out[25:15];
         default: z_in = '0;
      endcase
   end

   bc0_bist_ctrl #(
      .NUM_PATTERNS (4),
      .SEED         (26'h0000001),
      .GOLDEN_SIG   (11'h000)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .abort         (abort),
      .x_out         (x_out),
      .z_in          (z_in),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .signature     (signature),
      .pattern_count (pattern_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_x"},    32'(x_out),         32'h0);
      chk({tag, "_sig"},  32'(signature),     32'h0);
      chk({tag, "_cnt"},  32'(pattern_count), 32'h0);
      chk({tag, "_busy"}, 32'(busy),          32'h0);
      chk({tag, "_done"}, 32'(done),          32'h0);
      chk({tag, "_pass"}, 32'(pass),          32'h0);
   endtask

   // Returns at the falling edge inside cycle T+1.
   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   // Full 4-vector run; x sequence 1,3,6,D, final x held at 1B.
   task automatic run_full(input string tag, input logic [10:0] exp_sig,
                           input logic exp_pass, input bit restart_mid);
      pulse_start();
      chk({tag, "_t1_x"},    32'(x_out),         32'h1);
      chk({tag, "_t1_busy"}, 32'(busy),          32'h1);
      chk({tag, "_t1_cnt"},  32'(pattern_count), 32'h0);
      chk({tag, "_t1_pass"}, 32'(pass),          32'h0);
      @(negedge clk);
      if (restart_mid) start = 1'b1;
      chk({tag, "_t2_x"},    32'(x_out),         32'h3);
      chk({tag, "_t2_cnt"},  32'(pattern_count), 32'h1);
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_t3_x"},    32'(x_out),         32'h6);
      @(negedge clk);
      chk({tag, "_t4_x"},    32'(x_out),         32'hD);
      chk({tag, "_t4_cnt"},  32'(pattern_count), 32'h3);
      @(negedge clk);
      chk({tag, "_t5_busy"}, 32'(busy),          32'h1);
      chk({tag, "_t5_done"}, 32'(done),          32'h0);
      chk({tag, "_t5_cnt"},  32'(pattern_count), 32'h4);
      @(negedge clk);
      chk({tag, "_t6_done"}, 32'(done),          32'h1);
      chk({tag, "_t6_busy"}, 32'(busy),          32'h0);
      chk({tag, "_t6_pass"}, 32'(pass),          32'(exp_pass));
      chk({tag, "_t6_sig"},  32'(signature),     32'(exp_sig));
      chk({tag, "_t6_cnt"},  32'(pattern_count), 32'h4);
      chk({tag, "_t6_x"},    32'(x_out),         32'h1B);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b1;
      abort = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_outputs("rst_override");
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk_reset_outputs("idle_no_start");

      run_full("basic", 11'h000, 1'b1, 1'b0);
      repeat (3) @(negedge clk);
      chk("hold_done", 32'(done),  32'h1);
      chk("hold_pass", 32'(pass),  32'h1);
      chk("hold_x",    32'(x_out), 32'h1B);

      // z=1 each cycle: MISR 1,3,7,F
      z_mode = 1;
      run_full("zconst", 11'h00F, 1'b0, 1'b0);
      // z follows x (1,3,6,D): MISR 1,1,4,5
      z_mode = 2;
      run_full("zcomb", 11'h005, 1'b0, 1'b0);
      z_mode = 0;
      run_full("restart_ign", 11'h000, 1'b1, 1'b1);

      // Abort mid-run with z=1: one MISR step taken, then held.
      z_mode = 1;
      pulse_start();
      @(negedge clk) abort = 1'b1;
      @(negedge clk) abort = 1'b0;
      chk("abort_busy", 32'(busy),          32'h0);
      chk("abort_done", 32'(done),          32'h0);
      chk("abort_pass", 32'(pass),          32'h0);
      chk("abort_cnt",  32'(pattern_count), 32'h1);
      chk("abort_sig",  32'(signature),     32'h1);
      repeat (2) @(negedge clk);
      chk("abort_stay_idle", 32'(busy),     32'h0);
      z_mode = 0;
      run_full("post_abort", 11'h000, 1'b1, 1'b0);

      // Abort wins over simultaneous start in DONE.
      @(negedge clk) begin
         abort = 1'b1;
         start = 1'b1;
      end
      @(negedge clk) begin
         abort = 1'b0;
         start = 1'b0;
      end
      chk("abst_done", 32'(done),          32'h0);
      chk("abst_pass", 32'(pass),          32'h0);
      chk("abst_busy", 32'(busy),          32'h0);
      chk("abst_cnt",  32'(pattern_count), 32'h4);
      @(negedge clk);
      chk("abst_no_run", 32'(busy),        32'h0);

      // Reset during T+3 of a run.
      pulse_start();
      @(negedge clk);
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk);
      chk_reset_outputs("midrun_rst");
      rst_n = 1'b1;
      run_full("post_rst", 11'h000, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
